// File: rtl/aclk_pkg.sv
// Shared definitions for the alarm-clock keypad controller: state encodings,
// default key codes and small constant-width helpers.
package aclk_pkg;

  localparam logic [2:0] ST_SHOW_TIME        = 3'd0;
  localparam logic [2:0] ST_KEY_STORED       = 3'd1;
  localparam logic [2:0] ST_KEY_WAITED       = 3'd2;
  localparam logic [2:0] ST_KEY_ENTRY        = 3'd3;
  localparam logic [2:0] ST_SHOW_ALARM       = 3'd4;
  localparam logic [2:0] ST_SET_ALARM_TIME   = 3'd5;
  localparam logic [2:0] ST_SET_CURRENT_TIME = 3'd6;

  typedef enum logic [2:0] {
    SHOW_TIME        = ST_SHOW_TIME,
    KEY_STORED       = ST_KEY_STORED,
    KEY_WAITED       = ST_KEY_WAITED,
    KEY_ENTRY        = ST_KEY_ENTRY,
    SHOW_ALARM       = ST_SHOW_ALARM,
    SET_ALARM_TIME   = ST_SET_ALARM_TIME,
    SET_CURRENT_TIME = ST_SET_CURRENT_TIME
  } aclk_state_e;

  localparam int ACLK_NOKEY = 10;
  localparam int TIMER_W    = 4;

  function automatic int clog2_f(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // A single alarm still needs a 1-bit select port.
  function automatic int sel_w_f(input int n);
    return (n > 1) ? clog2_f(n) : 1;
  endfunction

endpackage

// File: rtl/aclk_ctrl_multi_sec_timer.sv
// Counts one_second pulses while enabled; time_out flags the pulse that
// completes TIMEOUT_SEC seconds since the last clear.
module aclk_sec_timer
  import aclk_pkg::*;
#(
  parameter int TIMEOUT_SEC = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               enable,
  input  logic               one_second,
  output logic               time_out,
  output logic [TIMER_W-1:0] count
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && one_second) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Fires on the pulse itself, so the FSM leaves in the same edge.
  assign time_out = enable && one_second && (count_q == TIMER_W'(TIMEOUT_SEC - 1));
  assign count    = count_q;

endmodule

// File: rtl/aclk_ctrl_multi.sv
// Keypad sequencing FSM for the alarm clock: digit entry, stuck-key and idle
// timeouts, and load strobes for the current-time counter and alarm bank.
module aclk_ctrl_multi
  import aclk_pkg::*;
#(
  parameter int NUM_ALARMS  = 2,
  parameter int TIMEOUT_SEC = 10,
  parameter int DIGITS      = 4,
  parameter int KEY_W       = 4,
  parameter int NOKEY       = ACLK_NOKEY,
  localparam int SEL_W      = sel_w_f(NUM_ALARMS),
  localparam int DCNT_W     = clog2_f(DIGITS + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  one_second,
  input  logic                  alarm_button,
  input  logic                  time_button,
  input  logic [KEY_W-1:0]      key,
  input  logic [SEL_W-1:0]      alarm_sel,
  output logic                  shift,
  output logic                  show_new_time,
  output logic                  show_a,
  output logic [SEL_W-1:0]      show_sel,
  output logic [NUM_ALARMS-1:0] load_new_a,
  output logic                  load_new_c,
  output logic                  reset_count,
  output logic                  entry_full,
  output logic [2:0]            state_dbg,
  output logic [TIMER_W-1:0]    timer_dbg,
  output logic [DCNT_W-1:0]     digit_cnt_dbg
);

  aclk_state_e           state_q, state_d;
  logic [DCNT_W-1:0]     digit_cnt_q, digit_cnt_d;
  logic [SEL_W-1:0]      show_sel_q, show_sel_d;
  logic                  shift_q, shift_d;
  logic                  show_new_time_q, show_new_time_d;
  logic                  show_a_q, show_a_d;
  logic [NUM_ALARMS-1:0] load_new_a_q, load_new_a_d;
  logic                  load_new_c_q, load_new_c_d;

  logic key_valid;
  logic in_wait;
  logic time_out;
  logic timer_clear;
  logic full;

  assign key_valid   = (key != KEY_W'(NOKEY));
  assign in_wait     = (state_q == KEY_WAITED) || (state_q == KEY_ENTRY);
  assign full        = (digit_cnt_q == DCNT_W'(DIGITS));
  assign timer_clear = !in_wait || (state_d != state_q);

  aclk_sec_timer #(
    .TIMEOUT_SEC(TIMEOUT_SEC)
  ) u_sec_timer (
    .clock      (clock),
    .reset      (reset),
    .clear      (timer_clear),
    .enable     (in_wait),
    .one_second (one_second),
    .time_out   (time_out),
    .count      (timer_dbg)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      SHOW_TIME: begin
        if (alarm_button)   state_d = SHOW_ALARM;
        else if (key_valid) state_d = KEY_STORED;
      end
      KEY_STORED: state_d = KEY_WAITED;
      KEY_WAITED: begin
        if (!key_valid)    state_d = KEY_ENTRY;
        else if (time_out) state_d = SHOW_TIME;
      end
      KEY_ENTRY: begin
        if (alarm_button)            state_d = SET_ALARM_TIME;
        else if (time_button)        state_d = SET_CURRENT_TIME;
        else if (time_out)           state_d = SHOW_TIME;
        else if (key_valid && !full) state_d = KEY_STORED;
      end
      SHOW_ALARM: begin
        if (!alarm_button) state_d = SHOW_TIME;
      end
      SET_ALARM_TIME:   state_d = SHOW_TIME;
      SET_CURRENT_TIME: state_d = SHOW_TIME;
      default:          state_d = SHOW_TIME;
    endcase

    digit_cnt_d = digit_cnt_q;
    if (state_q == SHOW_TIME) begin
      digit_cnt_d = '0;
    end else if ((state_q == KEY_STORED) && !full) begin
      digit_cnt_d = digit_cnt_q + 1'b1;
    end

    // Out-of-range selects fall back to alarm 0 so the strobe stays one-hot.
    show_sel_d = show_sel_q;
    if ((state_d != state_q) && ((state_d == SHOW_ALARM) || (state_d == SET_ALARM_TIME))) begin
      if (32'(alarm_sel) >= 32'(NUM_ALARMS)) show_sel_d = '0;
      else                                   show_sel_d = alarm_sel;
    end

    // Outputs are decoded from the next state so they land in the flop
    // alongside it and read as pure Moore decodes of the registered state.
    shift_d         = (state_d == KEY_STORED);
    show_new_time_d = (state_d == KEY_STORED) || (state_d == KEY_WAITED) ||
                      (state_d == KEY_ENTRY);
    show_a_d        = (state_d == SHOW_ALARM);
    load_new_c_d    = (state_d == SET_CURRENT_TIME);
    load_new_a_d    = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      load_new_a_d[i] = (state_d == SET_ALARM_TIME) && (show_sel_d == SEL_W'(i));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= SHOW_TIME;
      digit_cnt_q     <= '0;
      show_sel_q      <= '0;
      shift_q         <= 1'b0;
      show_new_time_q <= 1'b0;
      show_a_q        <= 1'b0;
      load_new_a_q    <= '0;
      load_new_c_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      digit_cnt_q     <= digit_cnt_d;
      show_sel_q      <= show_sel_d;
      shift_q         <= shift_d;
      show_new_time_q <= show_new_time_d;
      show_a_q        <= show_a_d;
      load_new_a_q    <= load_new_a_d;
      load_new_c_q    <= load_new_c_d;
    end
  end

  assign shift         = shift_q;
  assign show_new_time = show_new_time_q;
  assign show_a        = show_a_q;
  assign show_sel      = show_sel_q;
  assign load_new_a    = load_new_a_q;
  assign load_new_c    = load_new_c_q;
  assign reset_count   = load_new_c_q;
  assign entry_full    = full;
  assign state_dbg     = state_q;
  assign digit_cnt_dbg = digit_cnt_q;

endmodule

// File: tb/tb_aclk_ctrl_multi.sv
// Directed and randomized bench for aclk_ctrl_multi against a session-level
// reference model of the keypad controller.
module tb_aclk_ctrl_multi;
  import aclk_pkg::*;

  // Five alarms give a 3-bit select, so slots 5..7 are out of range.
  localparam int NUM_ALARMS  = 5;
  localparam int TIMEOUT_SEC = 10;
  localparam int DIGITS      = 4;
  localparam int KEY_W       = 4;
  localparam int NOKEY       = 10;
  localparam int SEL_W       = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
  localparam int DCNT_W      = $clog2(DIGITS + 1);
  localparam int OW          = NUM_ALARMS + SEL_W + 6;

  localparam int M_TIME = 0, M_STORED = 1, M_WAITED = 2, M_ENTRY = 3;
  localparam int M_SHOWA = 4, M_SETA = 5, M_SETC = 6;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic                  one_second = 1'b0;
  logic                  alarm_button = 1'b0;
  logic                  time_button = 1'b0;
  logic [KEY_W-1:0]      key = KEY_W'(NOKEY);
  logic [SEL_W-1:0]      alarm_sel = '0;
  logic                  shift, show_new_time, show_a, load_new_c, reset_count, entry_full;
  logic [SEL_W-1:0]      show_sel;
  logic [NUM_ALARMS-1:0] load_new_a;
  logic [2:0]            state_dbg;
  logic [3:0]            timer_dbg;
  logic [DCNT_W-1:0]     digit_cnt_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  int shift_seen = 0;

  int m_st, m_secs, m_digits, m_sel;

  aclk_ctrl_multi #(
    .NUM_ALARMS(NUM_ALARMS), .TIMEOUT_SEC(TIMEOUT_SEC), .DIGITS(DIGITS),
    .KEY_W(KEY_W), .NOKEY(NOKEY)
  ) dut (
    .clock(clock), .reset(reset), .one_second(one_second),
    .alarm_button(alarm_button), .time_button(time_button), .key(key),
    .alarm_sel(alarm_sel), .shift(shift), .show_new_time(show_new_time),
    .show_a(show_a), .show_sel(show_sel), .load_new_a(load_new_a),
    .load_new_c(load_new_c), .reset_count(reset_count), .entry_full(entry_full),
    .state_dbg(state_dbg), .timer_dbg(timer_dbg), .digit_cnt_dbg(digit_cnt_dbg)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_st = M_TIME; m_secs = 0; m_digits = 0; m_sel = 0;
  endtask

  // One clock of the session model: seconds counted since entering the
  // current waiting phase, digits captured since the last idle display.
  task automatic model_step();
    int  nst;
    int  nsecs;
    bit  waiting;
    bit  kv;
    kv      = (key != KEY_W'(NOKEY));
    waiting = (m_st == M_WAITED) || (m_st == M_ENTRY);
    nsecs   = m_secs + ((waiting && one_second) ? 1 : 0);
    nst     = m_st;
    case (m_st)
      M_TIME:   if (alarm_button) nst = M_SHOWA; else if (kv) nst = M_STORED;
      M_STORED: nst = M_WAITED;
      M_WAITED: if (!kv) nst = M_ENTRY; else if (nsecs == TIMEOUT_SEC) nst = M_TIME;
      M_ENTRY: begin
        if (alarm_button)                  nst = M_SETA;
        else if (time_button)              nst = M_SETC;
        else if (nsecs == TIMEOUT_SEC)     nst = M_TIME;
        else if (kv && m_digits < DIGITS)  nst = M_STORED;
      end
      M_SHOWA:  if (!alarm_button) nst = M_TIME;
      default:  nst = M_TIME;
    endcase
    if (m_st == M_TIME) m_digits = 0;
    else if (m_st == M_STORED && m_digits < DIGITS) m_digits++;
    if (nst != m_st && (nst == M_SHOWA || nst == M_SETA))
      m_sel = (int'(alarm_sel) < NUM_ALARMS) ? int'(alarm_sel) : 0;
    m_secs = (nst == m_st && waiting) ? nsecs : 0;
    m_st   = nst;
  endtask

  function automatic logic [OW-1:0] model_outs();
    logic [NUM_ALARMS-1:0] la;
    la = '0;
    if (m_st == M_SETA) la[m_sel] = 1'b1;
    return {m_st == M_STORED, (m_st == M_STORED || m_st == M_WAITED || m_st == M_ENTRY),
            m_st == M_SHOWA, la, m_st == M_SETC, m_st == M_SETC, m_digits == DIGITS,
            SEL_W'(m_sel)};
  endfunction

  function automatic logic [OW-1:0] dut_outs();
    return {shift, show_new_time, show_a, load_new_a, load_new_c, reset_count,
            entry_full, show_sel};
  endfunction

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    if (shift === 1'b1) shift_seen++;
    check("model_outs", 32'(dut_outs()), 32'(model_outs()));
  endtask

  // Asynchronous reset in the middle of a cycle; released on the next negedge.
  task automatic apply_reset();
    #2;
    reset = 1'b1;
    m_reset();
    #1;
    check("rst_outs", 32'(dut_outs()), 32'(0));
    check("rst_state", 32'(state_dbg), 32'(ST_SHOW_TIME));
    check("rst_timer", 32'(timer_dbg), 32'(0));
    check("rst_digits", 32'(digit_cnt_dbg), 32'(0));
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic press(input int k);
    key = KEY_W'(k);
    tick();
    key = KEY_W'(NOKEY);
    tick();
    tick();
  endtask

  task automatic pulse_after(input int gap);
    repeat (gap - 1) tick();
    one_second = 1'b1;
    tick();
    one_second = 1'b0;
  endtask

  initial begin
    int mode;
    logic [KEY_W-1:0] held;
    m_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("por_outs", 32'(dut_outs()), 32'(0));
    check("por_state", 32'(state_dbg), 32'(ST_SHOW_TIME));
    reset = 1'b0;

    // Key entry followed by alarm load into slot 1.
    shift_seen = 0;
    key = 4'd3;
    tick();
    check("t1_shift_on", 32'(shift), 32'(1));
    tick();
    check("t1_shift_off", 32'(shift), 32'(0));
    check("t1_waited", 32'(state_dbg), 32'(ST_KEY_WAITED));
    key = KEY_W'(NOKEY);
    tick();
    check("t1_entry", 32'(state_dbg), 32'(ST_KEY_ENTRY));
    check("t1_shift_count", 32'(shift_seen), 32'(1));
    alarm_sel = 3'd1;
    alarm_button = 1'b1;
    tick();
    check("t1_load_a", 32'(load_new_a), 32'(5'b00010));
    check("t1_sel", 32'(show_sel), 32'(1));
    alarm_button = 1'b0;
    tick();
    check("t1_load_a_off", 32'(load_new_a), 32'(0));
    check("t1_back", 32'(state_dbg), 32'(ST_SHOW_TIME));

    // Idle timeout in KEY_ENTRY after exactly TIMEOUT_SEC pulses.
    press(7);
    check("t2_entry", 32'(state_dbg), 32'(ST_KEY_ENTRY));
    for (int p = 1; p <= TIMEOUT_SEC; p++) begin
      pulse_after(5);
      if (p == TIMEOUT_SEC - 1) check("t2_pulse9", 32'(state_dbg), 32'(ST_KEY_ENTRY));
    end
    check("t2_timeout", 32'(state_dbg), 32'(ST_SHOW_TIME));
    check("t2_snt", 32'(show_new_time), 32'(0));

    // Stuck key times out of KEY_WAITED with a single shift.
    shift_seen = 0;
    key = 4'd5;
    tick();
    tick();
    for (int p = 1; p <= TIMEOUT_SEC; p++) begin
      pulse_after(5);
      if (p == TIMEOUT_SEC - 1) check("t3_pulse9", 32'(state_dbg), 32'(ST_KEY_WAITED));
    end
    key = KEY_W'(NOKEY);
    check("t3_timeout", 32'(state_dbg), 32'(ST_SHOW_TIME));
    check("t3_shift_count", 32'(shift_seen), 32'(1));

    // Digit limit, then set current time.
    tick();
    shift_seen = 0;
    for (int d = 1; d <= DIGITS; d++) begin
      press(d);
      if (d == DIGITS - 1) check("t4_not_full", 32'(entry_full), 32'(0));
    end
    check("t4_full", 32'(entry_full), 32'(1));
    key = 4'd9;
    tick();
    check("t4_ignored_state", 32'(state_dbg), 32'(ST_KEY_ENTRY));
    check("t4_ignored_shift", 32'(shift), 32'(0));
    key = KEY_W'(NOKEY);
    tick();
    check("t4_shift_count", 32'(shift_seen), 32'(DIGITS));
    time_button = 1'b1;
    tick();
    check("t4_load_c", 32'(load_new_c), 32'(1));
    check("t4_reset_count", 32'(reset_count), 32'(1));
    time_button = 1'b0;
    tick();
    check("t4_load_c_off", 32'(load_new_c), 32'(0));

    // Out-of-range alarm display, then alarm/time button priority.
    alarm_sel = 3'd7;
    alarm_button = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("t5_show_a", 32'(show_a), 32'(1));
      check("t5_show_sel", 32'(show_sel), 32'(0));
    end
    alarm_button = 1'b0;
    tick();
    check("t5_show_a_off", 32'(show_a), 32'(0));
    press(2);
    alarm_sel = 3'd2;
    alarm_button = 1'b1;
    time_button = 1'b1;
    tick();
    check("t5_prio_state", 32'(state_dbg), 32'(ST_SET_ALARM_TIME));
    check("t5_prio_no_c", 32'(load_new_c), 32'(0));
    check("t5_prio_load_a", 32'(load_new_a), 32'(5'b00100));
    alarm_button = 1'b0;
    time_button = 1'b0;
    tick();

    // Reset while waiting on a held key.
    key = 4'd5;
    tick();
    tick();
    one_second = 1'b1;
    tick();
    one_second = 1'b0;
    check("t6_waited", 32'(state_dbg), 32'(ST_KEY_WAITED));
    check("t6_timer", 32'(timer_dbg), 32'(1));
    key = KEY_W'(NOKEY);
    apply_reset();
    tick();
    check("t6_after", 32'(state_dbg), 32'(ST_SHOW_TIME));

    // Randomized segments: quiet, busy and stuck-key traffic.
    for (int seg = 0; seg < 60; seg++) begin
      mode = $urandom_range(0, 2);
      held = KEY_W'($urandom_range(0, 15));
      for (int c = 0; c < 40; c++) begin
        one_second = ($urandom_range(0, 2) == 0);
        alarm_sel  = SEL_W'($urandom_range(0, 7));
        case (mode)
          0: begin
            key = ($urandom_range(0, 19) == 0) ? KEY_W'($urandom_range(0, 15)) : KEY_W'(NOKEY);
            alarm_button = ($urandom_range(0, 49) == 0);
            time_button  = ($urandom_range(0, 49) == 0);
          end
          1: begin
            key = ($urandom_range(0, 1) == 0) ? KEY_W'($urandom_range(0, 15)) : KEY_W'(NOKEY);
            alarm_button = ($urandom_range(0, 7) == 0);
            time_button  = ($urandom_range(0, 7) == 0);
          end
          default: begin
            key = held;
            alarm_button = 1'b0;
            time_button  = 1'b0;
          end
        endcase
        if ($urandom_range(0, 299) == 0) apply_reset();
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
